// File: rtl/riscv_pkg.sv
// Shared RV32I core types for the ID/EX stage.
//   alu_op_e   : ALU opcode carried from decode to execute
//   srca_sel_e : ALU operand A source (rs1, pc, zero)
//   srcb_sel_e : ALU operand B source (rs2, immediate)
//   fwd_sel_e  : per-operand forwarding source (regfile, EX/MEM, MEM/WB)
package riscv_pkg;

  typedef enum logic [4:0] {
    ADD  = 5'd0,
    SUB  = 5'd1,
    SLL  = 5'd2,
    SLT  = 5'd3,
    SLTU = 5'd4,
    XOR  = 5'd5,
    SRL  = 5'd6,
    SRA  = 5'd7,
    OR   = 5'd8,
    AND  = 5'd9,
    LUI  = 5'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCA_RS1  = 2'd0,
    SRCA_PC   = 2'd1,
    SRCA_ZERO = 2'd2
  } srca_sel_e;

  typedef enum logic {
    SRCB_RS2 = 1'b0,
    SRCB_IMM = 1'b1
  } srcb_sel_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/forward_unit.sv
// Combinational operand forwarding for one source register.
//   rs, reg_data                 : registered source address and regfile value
//   mem_valid/reg_write/rd/result: EX/MEM writer (highest priority)
//   wb_valid/reg_write/rd/result : MEM/WB writer
//   data                         : selected operand value
// With Enable=0 the regfile value always passes through.
module forward_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REGW   = 5,
  parameter bit          Enable = 1'b1
) (
  input  logic [REGW-1:0] rs,
  input  logic [XLEN-1:0] reg_data,
  input  logic            mem_valid,
  input  logic            mem_reg_write,
  input  logic [REGW-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_valid,
  input  logic            wb_reg_write,
  input  logic [REGW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] data
);

  fwd_sel_e sel;

  // x0 is hardwired zero, so it is never forwarded.
  always_comb begin
    sel = FWD_REG;
    if (Enable && (rs != '0)) begin
      if (mem_valid && mem_reg_write && (mem_rd == rs)) begin
        sel = FWD_MEM;
      end else if (wb_valid && wb_reg_write && (wb_rd == rs)) begin
        sel = FWD_WB;
      end
    end
  end

  always_comb begin
    unique case (sel)
      FWD_MEM: data = mem_result;
      FWD_WB:  data = wb_result;
      default: data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32I 5-stage core.
// Build option: IDEX_FORWARD_EN
//   defined   : MEM/WB forwarding, only load-use inserts a bubble
//   undefined : no forwarding, bubbles while any EX/MEM/WB writer targets rs1/rs2
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   id_*                  : decoded instruction with valid/ready handshake
//   flush                 : redirect, kills stage contents at next edge
//   ex_ready / ex_valid   : downstream handshake
//   alu_opE, SrcA, SrcB   : execute ALU opcode and operands
//   ex_store_data, ex_rd, ex_pc, ex_reg_write/mem_read/mem_write : carried to EX/MEM
//   mem_*, wb_*           : downstream writer info for forwarding and hazards
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_alu_op,
  input  logic [1:0]      id_srca_sel,
  input  logic            id_srcb_sel,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [4:0]      alu_opE,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  output logic [XLEN-1:0] ex_store_data,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [XLEN-1:0] ex_pc,
  input  logic            mem_valid,
  input  logic            mem_reg_write,
  input  logic [REGW-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_valid,
  input  logic            wb_reg_write,
  input  logic [REGW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result
);

  logic            ex_valid_q;
  logic [4:0]      alu_op_q;
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [REGW-1:0] rs1_q, rs2_q, rd_q;
  srca_sel_e       srca_sel_q;
  srcb_sel_e       srcb_sel_q;
  logic            reg_write_q, mem_read_q, mem_write_q;
  logic            hazard;
  logic            load_en;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

`ifdef IDEX_FORWARD_EN
  localparam bit FwdEnable = 1'b1;

  // Load data is not ready until MEM completes: one bubble lets it reach WB.
  always_comb begin
    hazard = ex_valid_q && mem_read_q && (rd_q != '0) && id_valid &&
             ((rd_q == id_rs1) || (rd_q == id_rs2));
  end
`else
  localparam bit FwdEnable = 1'b0;

  logic rs1_busy, rs2_busy;

  // Without forwarding, wait until no in-flight writer targets a source.
  always_comb begin
    rs1_busy = (id_rs1 != '0) &&
               ((ex_valid_q && reg_write_q && (rd_q == id_rs1)) ||
                (mem_valid && mem_reg_write && (mem_rd == id_rs1)) ||
                (wb_valid && wb_reg_write && (wb_rd == id_rs1)));
    rs2_busy = (id_rs2 != '0) &&
               ((ex_valid_q && reg_write_q && (rd_q == id_rs2)) ||
                (mem_valid && mem_reg_write && (mem_rd == id_rs2)) ||
                (wb_valid && wb_reg_write && (wb_rd == id_rs2)));
    hazard   = id_valid && (rs1_busy || rs2_busy);
  end
`endif

  always_comb begin
    id_ready = (!ex_valid_q || ex_ready) && !hazard && !flush;
    load_en  = id_valid && id_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      alu_op_q    <= ADD;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      srca_sel_q  <= SRCA_RS1;
      srcb_sel_q  <= SRCB_RS2;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (load_en) begin
      ex_valid_q  <= 1'b1;
      alu_op_q    <= id_alu_op;
      pc_q        <= id_pc;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rd_q        <= id_rd;
      srca_sel_q  <= srca_sel_e'(id_srca_sel);
      srcb_sel_q  <= srcb_sel_e'(id_srcb_sel);
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
      mem_write_q <= id_mem_write;
    end else if (!ex_valid_q || ex_ready) begin
      // Drained with nothing to accept (empty decode or hazard bubble).
      ex_valid_q <= 1'b0;
    end
  end

  forward_unit #(
    .XLEN   (XLEN),
    .REGW   (REGW),
    .Enable (FwdEnable)
  ) u_fwd_rs1 (
    .rs            (rs1_q),
    .reg_data      (rs1_data_q),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .data          (rs1_fwd)
  );

  forward_unit #(
    .XLEN   (XLEN),
    .REGW   (REGW),
    .Enable (FwdEnable)
  ) u_fwd_rs2 (
    .rs            (rs2_q),
    .reg_data      (rs2_data_q),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .data          (rs2_fwd)
  );

  always_comb begin
    case (srca_sel_q)
      SRCA_RS1: SrcA = rs1_fwd;
      SRCA_PC:  SrcA = pc_q;
      default:  SrcA = '0;
    endcase
    SrcB          = (srcb_sel_q == SRCB_IMM) ? imm_q : rs2_fwd;
    ex_store_data = rs2_fwd;
    ex_valid      = ex_valid_q;
    alu_opE       = alu_op_q;
    ex_rd         = rd_q;
    ex_pc         = pc_q;
    ex_reg_write  = ex_valid_q && reg_write_q;
    ex_mem_read   = ex_valid_q && mem_read_q;
    ex_mem_write  = ex_valid_q && mem_write_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a slot-level reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_alu_op;
  logic [1:0]  id_srca_sel;
  logic        id_srcb_sel, id_reg_write, id_mem_read, id_mem_write;
  logic        flush, ex_ready, ex_valid;
  logic [4:0]  alu_opE, ex_rd;
  logic [31:0] SrcA, SrcB, ex_store_data, ex_pc;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        mem_valid, mem_reg_write, wb_valid, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_imm(id_imm), .id_alu_op(id_alu_op), .id_srca_sel(id_srca_sel),
    .id_srcb_sel(id_srcb_sel), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .alu_opE(alu_opE), .SrcA(SrcA), .SrcB(SrcB), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_pc(ex_pc), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_result(wb_result)
  );

  // Reference model: the instruction currently occupying the EX slot.
  typedef struct packed {
    logic        v;
    logic [4:0]  op;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  asel;
    logic        bsel, rw, mr, mw;
  } slot_t;

  slot_t m;

  function automatic bit writer_hits(input logic [4:0] r);
    return (m.v && m.rw && m.rd == r) || (mem_valid && mem_reg_write && mem_rd == r) ||
           (wb_valid && wb_reg_write && wb_rd == r);
  endfunction

  function automatic bit exp_ready();
    bit haz;
`ifdef IDEX_FORWARD_EN
    haz = m.v && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
`else
    haz = id_valid && ((id_rs1 != 0 && writer_hits(id_rs1)) ||
                       (id_rs2 != 0 && writer_hits(id_rs2)));
`endif
    return (!m.v || ex_ready) && !haz && !flush;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] regval);
`ifdef IDEX_FORWARD_EN
    if (rs != 0 && mem_valid && mem_reg_write && mem_rd == rs) return mem_result;
    if (rs != 0 && wb_valid && wb_reg_write && wb_rd == rs) return wb_result;
`endif
    return regval;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m = '0;
    end else begin
      bit rdy;
      rdy = exp_ready();
      if (flush) m.v = 1'b0;
      else if (id_valid && rdy)
        m = '{v: 1'b1, op: id_alu_op, pc: id_pc, d1: id_rs1_data, d2: id_rs2_data,
              imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd, asel: id_srca_sel,
              bsel: id_srcb_sel, rw: id_reg_write, mr: id_mem_read, mw: id_mem_write};
      else if (!m.v || ex_ready) m.v = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      logic [31:0] ea, eb;
      chk("m_ex_valid", 32'(ex_valid), 32'(m.v));
      chk("m_id_ready", 32'(id_ready), 32'(exp_ready()));
      chk("m_reg_write", 32'(ex_reg_write), 32'(m.v && m.rw));
      chk("m_mem_read", 32'(ex_mem_read), 32'(m.v && m.mr));
      chk("m_mem_write", 32'(ex_mem_write), 32'(m.v && m.mw));
      if (m.v) begin
        ea = (m.asel == 2'd0) ? operand(m.rs1, m.d1) : (m.asel == 2'd1) ? m.pc : 32'd0;
        eb = m.bsel ? m.imm : operand(m.rs2, m.d2);
        chk("m_alu_op", 32'(alu_opE), 32'(m.op));
        chk("m_srca", SrcA, ea);
        chk("m_srcb", SrcB, eb);
        chk("m_store", ex_store_data, operand(m.rs2, m.d2));
        chk("m_rd", 32'(ex_rd), 32'(m.rd));
        chk("m_pc", ex_pc, m.pc);
      end
    end
  end

  task automatic set_id(input bit v, input logic [4:0] op, input logic [4:0] rs1, rs2, rd,
                        input logic [31:0] d1, d2, imm, pc, input logic [1:0] asel,
                        input bit bsel, rw, mr, mw);
    id_valid = v; id_alu_op = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_pc = pc;
    id_srca_sel = asel; id_srcb_sel = bsel;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic id_idle();
    set_id(0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
  endtask

  task automatic set_mem(input bit v, input logic [4:0] rd, input logic [31:0] res);
    mem_valid = v; mem_reg_write = v; mem_rd = rd; mem_result = res;
  endtask

  task automatic set_wb(input bit v, input logic [4:0] rd, input logic [31:0] res);
    wb_valid = v; wb_reg_write = v; wb_rd = rd; wb_result = res;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    id_idle(); set_mem(0, 0, 0); set_wb(0, 0, 0);
    repeat (2) tick();
    at_neg();
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_alu_op", 32'(alu_opE), 0);
    chk("rst_srca", SrcA, 0);
    chk("rst_srcb", SrcB, 0);
    tick();
    rst_n = 1'b1;

    // add x3,x1,x2 then dependent add x4,x3,x3
    set_id(1, ADD, 5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 0, 32'h100, 2'd0, 0, 1, 0, 0);
    at_neg();
    chk("a_ready", 32'(id_ready), 1);
    tick();
    set_id(1, ADD, 5'd3, 5'd3, 5'd4, 32'd0, 32'd0, 0, 32'h104, 2'd0, 0, 1, 0, 0);
    at_neg();
    chk("a_srca", SrcA, 32'd10);
    chk("a_srcb", SrcB, 32'd20);
    chk("a_pc", ex_pc, 32'h100);
`ifdef IDEX_FORWARD_EN
    tick();
    id_idle(); set_mem(1, 5'd3, 32'd30); set_wb(1, 5'd3, 32'd99);
    at_neg();
    chk("fwd_mem_prio_a", SrcA, 32'd30);
    chk("fwd_mem_prio_b", SrcB, 32'd30);
    chk("fwd_store", ex_store_data, 32'd30);
    #1 set_mem(0, 0, 0);
    #1 chk("fwd_wb", SrcA, 32'd99);
    tick();
    set_wb(0, 0, 0);

    // lw x5,4(x1) then add x6,x5,x1: one load-use bubble
    set_id(1, ADD, 5'd1, 5'd0, 5'd5, 32'h1000, 0, 32'd4, 32'h108, 2'd0, 1, 1, 1, 0);
    tick();
    set_id(1, ADD, 5'd5, 5'd1, 5'd6, 32'd0, 32'd7, 0, 32'h10c, 2'd0, 0, 1, 0, 0);
    at_neg();
    chk("lu_srca", SrcA, 32'h1000);
    chk("lu_srcb_imm", SrcB, 32'd4);
    chk("lu_mem_read", 32'(ex_mem_read), 1);
    chk("lu_stall", 32'(id_ready), 0);
    tick();
    set_mem(1, 5'd5, 32'h1004);
    at_neg();
    chk("lu_bubble", 32'(ex_valid), 0);
    chk("lu_release", 32'(id_ready), 1);
    tick();
    id_idle(); set_mem(0, 0, 0); set_wb(1, 5'd5, 32'h55);
    at_neg();
    chk("lu_issue", 32'(ex_valid), 1);
    chk("lu_rd", 32'(ex_rd), 32'd6);
    chk("lu_fwd_wb", SrcA, 32'h55);
    chk("lu_srcb", SrcB, 32'd7);
    tick();
    set_wb(0, 0, 0);
`else
    chk("haz_ex", 32'(id_ready), 0);
    tick();
    set_mem(1, 5'd3, 32'd30);
    at_neg();
    chk("bubble1", 32'(ex_valid), 0);
    chk("haz_mem", 32'(id_ready), 0);
    tick();
    set_mem(0, 0, 0); set_wb(1, 5'd3, 32'd30);
    at_neg();
    chk("bubble2", 32'(ex_valid), 0);
    chk("haz_wb", 32'(id_ready), 0);
    tick();
    set_wb(0, 0, 0);
    set_id(1, ADD, 5'd3, 5'd3, 5'd4, 32'd30, 32'd30, 0, 32'h104, 2'd0, 0, 1, 0, 0);
    at_neg();
    chk("bubble3", 32'(ex_valid), 0);
    chk("haz_clear", 32'(id_ready), 1);
    tick();
    id_idle();
    at_neg();
    chk("nf_issue", 32'(ex_valid), 1);
    chk("nf_srca", SrcA, 32'd30);
    chk("nf_srcb", SrcB, 32'd30);
    chk("nf_rd", 32'(ex_rd), 32'd4);
    tick();
`endif

    // x0 is never forwarded
    set_id(1, ADD, 5'd0, 5'd0, 5'd7, 0, 0, 0, 32'h110, 2'd0, 0, 1, 0, 0);
    set_mem(1, 5'd0, 32'hDEAD);
    tick();
    id_idle();
    at_neg();
    chk("x0_valid", 32'(ex_valid), 1);
    chk("x0_no_fwd", SrcA, 32'd0);
    tick();
    set_mem(0, 0, 0);

    // Stall for three cycles, flush on the second
    set_id(1, SUB, 5'd1, 5'd2, 5'd8, 32'h11, 32'h22, 0, 32'h200, 2'd0, 0, 1, 0, 0);
    tick();
    ex_ready = 1'b0;
    set_id(1, ADD, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 0, 32'h204, 2'd0, 0, 1, 0, 0);
    at_neg();
    chk("st1_ready", 32'(id_ready), 0);
    chk("st1_op", 32'(alu_opE), 32'd1);
    chk("st1_srca", SrcA, 32'h11);
    tick();
    flush = 1'b1;
    at_neg();
    chk("st2_valid", 32'(ex_valid), 1);
    chk("st2_srcb", SrcB, 32'h22);
    chk("st2_ready", 32'(id_ready), 0);
    tick();
    flush = 1'b0;
    at_neg();
    chk("flush_kill", 32'(ex_valid), 0);
    chk("flush_gate_rw", 32'(ex_reg_write), 0);
    chk("after_flush_ready", 32'(id_ready), 1);
    tick();
    id_idle();
    at_neg();
    chk("next_issue_rd", 32'(ex_rd), 32'd9);
    chk("next_issue_srca", SrcA, 32'd1);

    // Asynchronous reset while stalled
    tick();
    at_neg();
    chk("held", 32'(ex_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ex_valid), 0);
    chk("arst_op", 32'(alu_opE), 0);
    chk("arst_srca", SrcA, 0);
    chk("arst_srcb", SrcB, 0);
    chk("arst_rw", 32'(ex_reg_write), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    ex_ready = 1'b1;
    tick();
    at_neg();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the RV32I 5-stage core.
- Registers decoded instruction fields on a valid/ready handshake.
- Resolves RAW hazards by MEM/WB forwarding plus load-use bubble insertion.
- Drives the execute ALU's alu_opE, SrcA and SrcB, plus the store data and control carried to EX/MEM.

Parameters:
XLEN, 32, datapath width
REGW, 5, register address width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode holds an instruction
id_ready  out  1  stage accepts id_* this cycle
id_pc  in  XLEN  instruction PC
id_rs1_data  in  XLEN  regfile read 1
id_rs2_data  in  XLEN  regfile read 2
id_rs1  in  REGW  source 1 address
id_rs2  in  REGW  source 2 address
id_rd  in  REGW  destination address
id_imm  in  XLEN  sign-extended immediate
id_alu_op  in  5  ALU opcode (pkg alu_op_e)
id_srca_sel  in  2  0 rs1, 1 pc, 2 zero
id_srcb_sel  in  1  0 rs2, 1 imm
id_reg_write  in  1  writes rd
id_mem_read  in  1  load
id_mem_write  in  1  store
flush  in  1  branch/jump redirect, kill stage contents
ex_ready  in  1  EX/MEM accepts this cycle
ex_valid  out  1  stage holds a live instruction
alu_opE  out  5  registered opcode to ALU
SrcA  out  XLEN  forwarded ALU operand A
SrcB  out  XLEN  forwarded ALU operand B
ex_store_data  out  XLEN  forwarded rs2 for stores
ex_rd  out  REGW  registered rd
ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered controls, gated by ex_valid
ex_pc  out  XLEN  registered PC
mem_valid, mem_reg_write  in  1 each  EX/MEM writer info
mem_rd  in  REGW  EX/MEM destination
mem_result  in  XLEN  EX/MEM ALU result
wb_valid, wb_reg_write  in  1 each  MEM/WB writer info
wb_rd  in  REGW  MEM/WB destination
wb_result  in  XLEN  MEM/WB writeback value

Behaviour:
- Reset, asynchronous: ex_valid=0; all registered fields 0; alu_opE=ADD (0). SrcA/SrcB/ex_store_data therefore read 0.
- Accept: id_valid && id_ready at a clock edge loads all fields. Outputs reflect the instruction the next cycle (1-cycle latency).
- Advance: ex_ready=1 releases the current content.
- Stall: ex_valid && !ex_ready holds every register unchanged and deasserts id_ready.
- load_use = ex_valid && ex_mem_read && ex_rd!=0 && id_valid && (ex_rd==id_rs1 || ex_rd==id_rs2).
- id_ready = (!ex_valid || ex_ready) && !load_use && !flush.
- load_use with ex_ready=1: load ex_valid=0 (bubble) and hold decode. Exactly one bubble per load-use.
- flush: ex_valid<=0 at the next edge, overriding accept and hold. flush during stall also kills the held instruction.
- Forwarding, evaluated combinationally on the registered rs1/rs2, for each source:
  - MEM if mem_valid && mem_reg_write && mem_rd!=0 && mem_rd==rs.
  - Else WB with the same conditions.
  - Else registered regfile data.
  - MEM has priority over WB; x0 is never forwarded.
- SrcA = sel 0: forwarded rs1; sel 1: ex_pc; sel 2: 0.
- SrcB = imm if srcb_sel=1, else forwarded rs2.
- ex_store_data is always forwarded rs2.
- All arithmetic is pass-through; no width change.
- ex_reg_write, ex_mem_read and ex_mem_write are forced 0 when ex_valid=0.

Optional Feature:
IDEX_FORWARD_EN
- Defined: forwarding as above; only load-use stalls.
- Undefined: no forwarding muxes; SrcA/SrcB use registered regfile data.
  - Hazard = ID rs1/rs2 (nonzero) matches a writing valid rd in EX, MEM or WB.
  - On hazard, insert bubbles until it clears (up to 3 cycles). id_ready rule uses hazard in place of load_use.

Decomposition:
- Shared package riscv_pkg holds:
  - alu_op_e: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, LUI=10.
  - srca_sel_e, srcb_sel_e, fwd_sel_e {FWD_REG, FWD_MEM, FWD_WB}.
- One sub-module forward_unit (combinational): selects the source per operand, instantiated twice.

Test Plan:
- Reset mid-stall (ex_valid=1, ex_ready=0), rst_n low -> ex_valid=0, alu_opE=0, SrcA=SrcB=0 immediately, no clock needed.
- add x3,x1,x2 (rs1=10, rs2=20), then dependent add x4,x3,x3 with mem_result=30 -> SrcA=SrcB=30. Same rd in both MEM and WB (WB=99) -> MEM value 30 wins.
- lw x5 in EX, then add x6,x5,x1 in ID -> id_ready=0 for 1 cycle, one bubble (ex_valid=0), add issues next cycle.
- Write to x0 in MEM with mem_result=0xDEAD, ID reads x0 -> SrcA = regfile value 0, not forwarded.
- ex_ready=0 for 3 cycles -> outputs stable, id_ready=0. flush asserted on cycle 2 -> ex_valid=0 the next cycle and the instruction is dropped.
- IDEX_FORWARD_EN undefined, back-to-back dependent adds -> 3 bubbles, SrcA = regfile value after WB completes.
